// File: rtl/mips_wb_result_checker.sv
// Self-check monitor for the WB register-write port: compares each write against a loaded
// table of (register, data) expectations and reports per-entry pass/fail, strays and timeout.
module mips_wb_result_checker #(
  parameter int unsigned NUM_TESTS      = 24,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned CNT_W = $clog2(NUM_TESTS + 1),
  localparam int unsigned IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reg_write_WB,
  input  logic [REG_AW-1:0]    write_register_addr_WB,
  input  logic [DATA_W-1:0]    write_back_data_WB,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [REG_AW-1:0]    load_reg,
  input  logic [DATA_W-1:0]    load_data,
  input  logic                 start,
  input  logic                 mode_in_order,
  output logic [NUM_TESTS-1:0] pass_vec,
  output logic [NUM_TESTS-1:0] fail_vec,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic [7:0]           stray_count,
  output logic [31:0]          cycle_count,
  output logic                 busy,
  output logic                 done,
  output logic                 all_pass,
  output logic                 timeout
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [NUM_TESTS-1:0]  en_q, en_d, pass_q, pass_d, fail_q, fail_d;
  logic [7:0]            stray_q, stray_d;
  logic [31:0]           cycle_q, cycle_d;
  logic                  timeout_q, timeout_d;
  logic [REG_AW-1:0]     tbl_reg  [NUM_TESTS];
  logic [DATA_W-1:0]     tbl_data [NUM_TESTS];

  logic                  load_ok;
  logic [NUM_TESTS-1:0]  pending;
  logic                  any_hit, ptr_valid, hit;
  logic [IDX_W-1:0]      any_sel, ptr_sel, sel;
  logic [CNT_W-1:0]      pass_cnt, fail_cnt, en_cnt;

  assign load_ok = load_en && (state_q != StRun) && (32'(load_idx) < NUM_TESTS);
  assign pending = en_q & ~(pass_q | fail_q);

  // Lowest pending entry (in-order pointer) and lowest pending entry matching the address.
  always_comb begin
    any_hit   = 1'b0;
    any_sel   = '0;
    ptr_valid = 1'b0;
    ptr_sel   = '0;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      if (!ptr_valid && pending[i]) begin
        ptr_valid = 1'b1;
        ptr_sel   = IDX_W'(i);
      end
      if (!any_hit && pending[i] && (tbl_reg[i] == write_register_addr_WB)) begin
        any_hit = 1'b1;
        any_sel = IDX_W'(i);
      end
    end
    if (mode_in_order) begin
      hit = ptr_valid && (tbl_reg[ptr_sel] == write_register_addr_WB);
      sel = ptr_sel;
    end else begin
      hit = any_hit;
      sel = any_sel;
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    stray_d   = stray_q;
    cycle_d   = cycle_q;
    timeout_d = timeout_q;
    if (load_ok) en_d[load_idx] = 1'b1;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          pass_d    = '0;
          fail_d    = '0;
          stray_d   = '0;
          cycle_d   = '0;
          timeout_d = 1'b0;
        end
      end
      StRun: begin
        cycle_d = cycle_q + 32'd1;
        if (reg_write_WB) begin
          if (hit) begin
            if (write_back_data_WB == tbl_data[sel]) pass_d[sel] = 1'b1;
            else                                     fail_d[sel] = 1'b1;
          end else if (stray_q != 8'hFF) begin
            stray_d = stray_q + 8'd1;
          end
        end
        // Completion is tested after this edge's resolution so it wins over the timeout.
        if ((en_q & ~(pass_d | fail_d)) == '0) begin
          state_d = StDone;
        end else if (cycle_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      en_q      <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      stray_q   <= '0;
      cycle_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      stray_q   <= stray_d;
      cycle_q   <= cycle_d;
      timeout_q <= timeout_d;
    end
  end

  // Table contents are deliberately not reset; only the enable bits are.
  always_ff @(posedge clk) begin
    if (!reset && load_ok) begin
      tbl_reg[load_idx]  <= load_reg;
      tbl_data[load_idx] <= load_data;
    end
  end

  always_comb begin
    pass_cnt = '0;
    fail_cnt = '0;
    en_cnt   = '0;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      pass_cnt = pass_cnt + CNT_W'(pass_q[i]);
      fail_cnt = fail_cnt + CNT_W'(fail_q[i]);
      en_cnt   = en_cnt + CNT_W'(en_q[i]);
    end
  end

  assign pass_vec    = pass_q;
  assign fail_vec    = fail_q;
  assign pass_count  = pass_cnt;
  assign fail_count  = fail_cnt;
  assign stray_count = stray_q;
  assign cycle_count = cycle_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign timeout     = timeout_q;
  assign all_pass    = done && !timeout_q && (fail_cnt == '0) && (pass_cnt == en_cnt);

endmodule

// File: tb/tb_mips_wb_result_checker.sv
// Randomized and directed bench for mips_wb_result_checker against a queue-based reference model.
module tb_mips_wb_result_checker;

  localparam int NT = 6;
  localparam int IW = 3;
  localparam int CW = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int T  = 300;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_write_WB;
  logic [AW-1:0] write_register_addr_WB;
  logic [DW-1:0] write_back_data_WB;
  logic          load_en;
  logic [IW-1:0] load_idx;
  logic [AW-1:0] load_reg;
  logic [DW-1:0] load_data;
  logic          start;
  logic          mode_in_order;
  logic [NT-1:0] pass_vec, fail_vec;
  logic [CW-1:0] pass_count, fail_count;
  logic [7:0]    stray_count;
  logic [31:0]   cycle_count;
  logic          busy, done, all_pass, timeout;

  mips_wb_result_checker #(
    .NUM_TESTS(NT), .DATA_W(DW), .REG_AW(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .reg_write_WB(reg_write_WB),
    .write_register_addr_WB(write_register_addr_WB), .write_back_data_WB(write_back_data_WB),
    .load_en(load_en), .load_idx(load_idx), .load_reg(load_reg), .load_data(load_data),
    .start(start), .mode_in_order(mode_in_order), .pass_vec(pass_vec), .fail_vec(fail_vec),
    .pass_count(pass_count), .fail_count(fail_count), .stray_count(stray_count),
    .cycle_count(cycle_count), .busy(busy), .done(done), .all_pass(all_pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 run, 2 done; pending holds unresolved enabled entries in order.
  int            m_st;
  logic [NT-1:0] m_en, m_pass, m_fail;
  logic [AW-1:0] m_reg  [NT];
  logic [DW-1:0] m_data [NT];
  int            m_stray, m_cycle;
  logic          m_timeout;
  int            pending[$];
  int            n_checks = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int hit, idx;
    if (reset) begin
      m_st = 0; m_en = '0; m_pass = '0; m_fail = '0;
      m_stray = 0; m_cycle = 0; m_timeout = 1'b0;
      pending.delete();
      return;
    end
    if (m_st == 1) begin
      m_cycle++;
      if (reg_write_WB) begin
        hit = -1;
        if (mode_in_order) begin
          if (pending.size() > 0 && m_reg[pending[0]] == write_register_addr_WB) hit = 0;
        end else begin
          foreach (pending[k]) if (hit < 0 && m_reg[pending[k]] == write_register_addr_WB) hit = k;
        end
        if (hit >= 0) begin
          idx = pending[hit];
          if (m_data[idx] == write_back_data_WB) m_pass[idx] = 1'b1;
          else m_fail[idx] = 1'b1;
          pending.delete(hit);
        end else if (m_stray < 255) begin
          m_stray++;
        end
      end
      if (pending.size() == 0) m_st = 2;
      else if (m_cycle == T) begin
        m_st = 2;
        m_timeout = 1'b1;
      end
    end else begin
      if (load_en && int'(load_idx) < NT) begin
        m_reg[load_idx]  = load_reg;
        m_data[load_idx] = load_data;
        m_en[load_idx]   = 1'b1;
      end
      if (start) begin
        m_st = 1; m_pass = '0; m_fail = '0; m_stray = 0; m_cycle = 0; m_timeout = 1'b0;
        pending.delete();
        for (int i = 0; i < NT; i++) if (m_en[i]) pending.push_back(i);
      end
    end
  endtask

  task automatic compare_all();
    logic exp_all;
    exp_all = (m_st == 2) && !m_timeout && (m_fail == '0) && ($countones(m_pass) == $countones(m_en));
    check("pass_vec", 64'(pass_vec), 64'(m_pass));
    check("fail_vec", 64'(fail_vec), 64'(m_fail));
    check("pass_count", 64'(pass_count), 64'($countones(m_pass)));
    check("fail_count", 64'(fail_count), 64'($countones(m_fail)));
    check("stray_count", 64'(stray_count), 64'(m_stray));
    check("cycle_count", 64'(cycle_count), 64'(m_cycle));
    check("busy", 64'(busy), 64'(m_st == 1));
    check("done", 64'(done), 64'(m_st == 2));
    check("timeout", 64'(timeout), 64'(m_timeout));
    check("all_pass", 64'(all_pass), 64'(exp_all));
  endtask

  task automatic clr_inputs();
    reset = 1'b0; reg_write_WB = 1'b0; write_register_addr_WB = '0; write_back_data_WB = '0;
    load_en = 1'b0; load_idx = '0; load_reg = '0; load_data = '0; start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    clr_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic load(input int idx, input int r, input logic [DW-1:0] d);
    load_en = 1'b1; load_idx = IW'(idx); load_reg = AW'(r); load_data = d;
    tick();
  endtask

  task automatic wb(input int r, input logic [DW-1:0] d);
    reg_write_WB = 1'b1; write_register_addr_WB = AW'(r); write_back_data_WB = d;
    tick();
  endtask

  task automatic go(input logic m);
    mode_in_order = m; start = 1'b1;
    tick();
  endtask

  initial begin
    clr_inputs();
    mode_in_order = 1'b0;
    do_reset();
    check("reset_done", 64'(done), 64'h0);
    check("reset_pass_vec", 64'(pass_vec), 64'h0);

    // Two passing entries in order.
    load(0, 8, 32'h9999_9999); load(1, 9, 32'h0); go(1'b0);
    wb(8, 32'h9999_9999); wb(9, 32'h0);
    check("t1_pass_vec", 64'(pass_vec), 64'h3);
    check("t1_done", 64'(done), 64'h1);
    check("t1_all_pass", 64'(all_pass), 64'h1);

    // Data mismatch fails; later writes after DONE change nothing.
    do_reset(); load(0, 12, 32'h0); go(1'b0);
    wb(12, 32'h1);
    check("t2_fail_vec", 64'(fail_vec), 64'h1);
    check("t2_fail_count", 64'(fail_count), 64'h1);
    check("t2_all_pass", 64'(all_pass), 64'h0);
    wb(12, 32'h0);
    check("t2_pass_vec_after", 64'(pass_vec), 64'h0);

    // Any-order: same register, lowest index takes the first write.
    do_reset(); load(0, 5, 32'h64); load(1, 5, 32'hC7); go(1'b0);
    wb(5, 32'hC7);
    check("t3_fail_vec", 64'(fail_vec), 64'h1);
    wb(5, 32'hC7);
    check("t3_pass_vec", 64'(pass_vec), 64'h2);

    // In-order: out-of-order write is a stray.
    do_reset(); load(0, 28, 32'h1000_0000); load(1, 3, 32'h1); go(1'b1);
    wb(3, 32'h1);
    check("t4_stray", 64'(stray_count), 64'h1);
    wb(28, 32'h1000_0000); wb(3, 32'h1);
    check("t4_pass_vec", 64'(pass_vec), 64'h3);
    check("t4_all_pass", 64'(all_pass), 64'h1);
    mode_in_order = 1'b0;

    // Stray saturation then timeout.
    do_reset(); load(0, 7, 32'h5); go(1'b0);
    for (int i = 0; i < T && !done; i++) begin
      if (i < 270) begin
        reg_write_WB = 1'b1; write_register_addr_WB = 5'd1;
      end
      tick();
    end
    check("t5_stray_sat", 64'(stray_count), 64'd255);
    check("t5_timeout", 64'(timeout), 64'h1);
    check("t5_cycle_count", 64'(cycle_count), 64'(T));

    // Out-of-range index ignored; reset mid-run; empty table finishes immediately.
    do_reset(); load(6, 2, 32'h0); load(1, 2, 32'h0); go(1'b0); tick(); tick();
    do_reset();
    check("t6_busy", 64'(busy), 64'h0);
    check("t6_cycle", 64'(cycle_count), 64'h0);
    go(1'b0); tick();
    check("t6_done", 64'(done), 64'h1);
    check("t6_all_pass", 64'(all_pass), 64'h1);

    // Randomized runs.
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      for (int l = 0; l < int'($urandom_range(0, 5)); l++)
        load(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)), DW'($urandom_range(0, 1)));
      mode_in_order = 1'($urandom_range(0, 1));
      start = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        load_en = 1'b1; load_idx = IW'($urandom_range(0, 7));
        load_reg = AW'($urandom_range(1, 4)); load_data = DW'($urandom_range(0, 1));
      end
      tick();
      for (int c = 0; c < 40 && m_st == 1; c++) begin
        reg_write_WB = ($urandom_range(0, 3) != 0);
        write_register_addr_WB = AW'($urandom_range(1, 4));
        write_back_data_WB = DW'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) begin
          load_en = 1'b1; load_idx = IW'($urandom_range(0, 7)); load_reg = AW'($urandom_range(1, 4));
        end
        if ($urandom_range(0, 9) == 0) start = 1'b1;
        if ($urandom_range(0, 49) == 0) reset = 1'b1;
        tick();
      end
      for (int c = 0; c < 3; c++) begin
        reg_write_WB = 1'b1; write_register_addr_WB = AW'($urandom_range(1, 4));
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
